// File: rtl/data_mem_bs.sv
// Word-addressed data memory with byte strobes, configurable wait states and a
// one-cycle ready/err response strobe per accepted request.
module data_mem_bs #(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        mem_req_i,
   input  logic        write_enable_i,
   input  logic [3:0]  byte_enable_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] write_data_i,
   output logic [31:0] read_data_o,
   output logic        ready_o,
   output logic        err_o
);

   localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic        we_q;
   logic [3:0]  be_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        ready_q;
   logic        err_q;
   logic [31:0] rdata_q;
   logic [31:0] mem_q [DEPTH_WORDS];

   logic             in_wait;
   logic             accept;
   logic             do_access;
   logic             a_we;
   logic [3:0]       a_be;
   logic [31:0]      a_addr;
   logic [31:0]      a_wdata;
   logic [31:0]      offset;
   logic             below;
   logic             a_err;
   logic [IDX_W-1:0] a_idx;

   assign in_wait   = (state_q == WAIT);
   assign accept    = mem_req_i && !in_wait;
   assign do_access = in_wait ? (cnt_q == 4'd0) : (accept && (WAIT_CYCLES == 0));

   // With no wait states the access happens on the acceptance edge itself,
   // so the operands come straight from the inputs rather than the latches.
   assign a_we    = in_wait ? we_q    : write_enable_i;
   assign a_be    = in_wait ? be_q    : byte_enable_i;
   assign a_addr  = in_wait ? addr_q  : addr_i;
   assign a_wdata = in_wait ? wdata_q : write_data_i;

   // Borrow out of the subtraction flags addresses below BASE_ADDR.
   assign {below, offset} = {1'b0, a_addr} - {1'b0, BASE_ADDR};
   assign a_idx = offset[IDX_W+1:2];
   assign a_err = below || (offset[1:0] != 2'b00) || (offset[31:IDX_W+2] != '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         be_q    <= 4'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         ready_q <= do_access;
         err_q   <= do_access && a_err;
         if (do_access) begin
            if (a_err)
               rdata_q <= 32'd0;
            else if (!a_we)
               rdata_q <= mem_q[a_idx];
         end
         case (state_q)
            WAIT: begin
               if (cnt_q == 4'd0)
                  state_q <= RESP;
               else
                  cnt_q <= cnt_q - 4'd1;
            end
            default: begin
               if (accept) begin
                  we_q    <= write_enable_i;
                  be_q    <= byte_enable_i;
                  addr_q  <= addr_i;
                  wdata_q <= write_data_i;
                  if (WAIT_CYCLES == 0) begin
                     state_q <= RESP;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= CNT_INIT;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
         endcase
      end
   end

   // Storage has no reset; held-in-reset requests must not write.
   always_ff @(posedge clk_i) begin
      if (rst_ni && do_access && a_we && !a_err) begin
         for (int k = 0; k < 4; k++) begin
            if (a_be[k])
               mem_q[a_idx][8*k +: 8] <= a_wdata[8*k +: 8];
         end
      end
   end

   assign read_data_o = rdata_q;
   assign ready_o     = ready_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_data_mem_bs.sv
// Directed bench: one instance with no wait states, one with three.
module tb_data_mem_bs;

   logic        clk;
   logic        rst_n;

   logic        req0, we0, rdy0, err0;
   logic [3:0]  be0;
   logic [31:0] addr0, wd0, rd0;

   logic        req3, we3, rdy3, err3;
   logic [3:0]  be3;
   logic [31:0] addr3, wd3, rd3;

   int total = 0;
   int bad   = 0;

   data_mem_bs #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u0 (
      .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req0), .write_enable_i(we0),
      .byte_enable_i(be0), .addr_i(addr0), .write_data_i(wd0),
      .read_data_o(rd0), .ready_o(rdy0), .err_o(err0));

   data_mem_bs #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u3 (
      .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req3), .write_enable_i(we3),
      .byte_enable_i(be3), .addr_i(addr3), .write_data_i(wd3),
      .read_data_o(rd3), .ready_o(rdy3), .err_o(err3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance past one rising edge; outputs then show the following cycle.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set0(input logic r, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
      req0 = r; we0 = w; be0 = b; addr0 = a; wd0 = d;
   endtask

   task automatic set3(input logic r, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
      req3 = r; we3 = w; be3 = b; addr3 = a; wd3 = d;
   endtask

   initial begin
      rst_n = 1'b1;
      set0(0, 0, 4'h0, 32'h0, 32'h0);
      set3(0, 0, 4'h0, 32'h0, 32'h0);

      // async reset mid-cycle, before any clock edge
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ready0", {31'd0, rdy0}, 32'd0);
      chk("rst_err0",   {31'd0, err0}, 32'd0);
      chk("rst_rdata0", rd0, 32'd0);
      chk("rst_ready3", {31'd0, rdy3}, 32'd0);
      cyc();
      rst_n = 1'b1;
      cyc();
      cyc();
      chk("idle_ready0", {31'd0, rdy0}, 32'd0);
      chk("idle_ready3", {31'd0, rdy3}, 32'd0);

      // zero wait states: write then back-to-back read
      set0(1, 1, 4'hF, 32'h10, 32'hDEAD_BEEF);
      cyc();
      chk("w0_wr_ready", {31'd0, rdy0}, 32'd1);
      chk("w0_wr_err",   {31'd0, err0}, 32'd0);
      set0(1, 0, 4'h0, 32'h10, 32'h0);
      cyc();
      chk("w0_rd_ready", {31'd0, rdy0}, 32'd1);
      chk("w0_rd_data",  rd0, 32'hDEAD_BEEF);
      set0(0, 0, 4'h0, 32'h0, 32'h0);
      cyc();
      chk("w0_drop_ready", {31'd0, rdy0}, 32'd0);
      chk("w0_hold_data",  rd0, 32'hDEAD_BEEF);

      // byte strobes
      set0(1, 1, 4'hF, 32'h20, 32'h1122_3344);
      cyc();
      set0(1, 1, 4'b0101, 32'h20, 32'hAABB_CCDD);
      cyc();
      set0(1, 0, 4'h0, 32'h20, 32'h0);
      cyc();
      chk("be_merge", rd0, 32'h11BB_33DD);
      set0(1, 1, 4'b0000, 32'h20, 32'hFFFF_FFFF);
      cyc();
      chk("be0_ready",    {31'd0, rdy0}, 32'd1);
      chk("be0_rd_holds", rd0, 32'h11BB_33DD);
      set0(1, 0, 4'h0, 32'h20, 32'h0);
      cyc();
      chk("be0_nochange", rd0, 32'h11BB_33DD);

      // errors
      set0(1, 1, 4'hF, 32'h0, 32'hCAFE_F00D);
      cyc();
      set0(1, 0, 4'h0, 32'h2, 32'h0);
      cyc();
      chk("mis_ready", {31'd0, rdy0}, 32'd1);
      chk("mis_err",   {31'd0, err0}, 32'd1);
      chk("mis_data",  rd0, 32'd0);
      set0(1, 0, 4'h0, 32'h0, 32'h0);
      cyc();
      chk("w0_good_err",  {31'd0, err0}, 32'd0);
      chk("w0_good_data", rd0, 32'hCAFE_F00D);
      set0(1, 0, 4'h0, 32'h4000, 32'h0);
      cyc();
      chk("oor_rd_err",  {31'd0, err0}, 32'd1);
      chk("oor_rd_data", rd0, 32'd0);
      set0(1, 1, 4'hF, 32'h4000, 32'h1234_5678);
      cyc();
      chk("oor_wr_ready", {31'd0, rdy0}, 32'd1);
      chk("oor_wr_err",   {31'd0, err0}, 32'd1);
      set0(1, 0, 4'h0, 32'h0, 32'h0);
      cyc();
      chk("oor_wr_word0", rd0, 32'hCAFE_F00D);
      set0(0, 0, 4'h0, 32'h0, 32'h0);
      cyc();
      chk("err_clear", {31'd0, err0}, 32'd0);

      // three wait states: write, then read with inputs toggled during WAIT
      set3(1, 1, 4'hF, 32'h10, 32'h600D_CAFE);
      cyc();
      set3(0, 0, 4'h0, 32'h0, 32'h0);
      chk("w3_wr_n1", {31'd0, rdy3}, 32'd0);
      cyc();
      chk("w3_wr_n2", {31'd0, rdy3}, 32'd0);
      cyc();
      chk("w3_wr_n3", {31'd0, rdy3}, 32'd0);
      cyc();
      chk("w3_wr_n4", {31'd0, rdy3}, 32'd1);
      cyc();
      chk("w3_wr_n5", {31'd0, rdy3}, 32'd0);
      set3(1, 0, 4'h0, 32'h10, 32'h0);
      cyc();
      set3(1, 1, 4'hF, 32'h2, 32'hFFFF_FFFF);
      cyc();
      set3(1, 0, 4'h0, 32'h4000, 32'h0);
      cyc();
      chk("w3_rd_n3", {31'd0, rdy3}, 32'd0);
      cyc();
      set3(0, 0, 4'h0, 32'h0, 32'h0);
      chk("w3_rd_ready", {31'd0, rdy3}, 32'd1);
      chk("w3_rd_err",   {31'd0, err3}, 32'd0);
      chk("w3_rd_data",  rd3, 32'h600D_CAFE);
      cyc();
      chk("w3_rd_n5", {31'd0, rdy3}, 32'd0);

      // reset while a write sits in WAIT
      set3(1, 1, 4'hF, 32'h8, 32'h0);
      cyc();
      set3(0, 0, 4'h0, 32'h0, 32'h0);
      cyc(); cyc(); cyc(); cyc();
      set3(1, 1, 4'hF, 32'h8, 32'h5555_5555);
      cyc();
      set3(0, 0, 4'h0, 32'h0, 32'h0);
      cyc();
      rst_n = 1'b0;
      #1;
      chk("rstw_ready", {31'd0, rdy3}, 32'd0);
      cyc();
      cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("rstw_nopulse", {31'd0, rdy3}, 32'd0);
      end
      set3(1, 0, 4'h0, 32'h8, 32'h0);
      cyc();
      set3(0, 0, 4'h0, 32'h0, 32'h0);
      cyc(); cyc(); cyc();
      chk("rstw_rd_ready", {31'd0, rdy3}, 32'd1);
      chk("rstw_rd_data",  rd3, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_mem_bs.md
# data_mem_bs

Word-addressed data memory with per-byte write strobes, a configurable number of wait states and a request/ready handshake, replacing the fixed single-cycle data memory on the core's load/store path. It keeps the same request/write-enable/address/data port style, adds `ready_o` so the core can stall on slow memory, and adds `err_o` for misaligned or out-of-range accesses.

## Interface
- `DEPTH_WORDS`, 4096: number of 32-bit words; a power of two, at least 2.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to `DEPTH_WORDS*4`.
- `WAIT_CYCLES`, 0: extra cycles between acceptance and the access; range 0–15.
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `mem_req_i` in 1: access request.
- `write_enable_i` in 1: 1 = write, 0 = read.
- `byte_enable_i` in 4: write strobes; bit k selects `write_data_i[8k+7:8k]`.
- `addr_i` in 32: byte address.
- `write_data_i` in 32: write data.
- `read_data_o` out 32: read data, registered.
- `ready_o` out 1: response strobe, high for exactly one cycle per accepted request.
- `err_o` out 1: error flag, valid only while `ready_o`=1.

## Operation
- Storage is `DEPTH_WORDS` × 32 bits. It has no reset, so contents are undefined until written.
- States:
  - IDLE: no request pending.
  - WAIT: accepted, counting wait cycles.
  - RESP: `ready_o`=1.
- A request is accepted on a rising edge with `mem_req_i`=1 while in IDLE or RESP.
  - On acceptance, `write_enable_i`, `byte_enable_i`, `addr_i` and `write_data_i` are latched.
  - `mem_req_i` and all inputs are ignored while in WAIT.
- Transitions:
  - IDLE/RESP → WAIT on acceptance when `WAIT_CYCLES`>0, with the counter loaded to `WAIT_CYCLES`-1.
  - IDLE/RESP → RESP on acceptance when `WAIT_CYCLES`=0.
  - WAIT → RESP when the counter is 0; otherwise the counter decrements.
  - RESP → IDLE when there is no new request.
- Address check on the latched address: `offset = addr - BASE_ADDR` (32-bit, wrapping); `index = offset[31:2]`.
- Error when `addr[1:0]`≠0, OR `addr < BASE_ADDR`, OR `index ≥ DEPTH_WORDS`.
- The access is performed on the edge that enters RESP.
  - Write, no error: only the bytes with a set strobe are updated. `byte_enable_i`=0 completes normally with no change. `read_data_o` is unchanged.
  - Read, no error: `read_data_o` ← full word; strobes are ignored.
  - Any error: memory is not modified; `read_data_o` ← 0; `err_o`=1 for the RESP cycle.
- `read_data_o` holds its value until the next completed read or error response.

## Timing
- Reset values, all asynchronous: state IDLE, counter 0, `ready_o`=0, `err_o`=0, `read_data_o`=0.
- Latency: request sampled at edge N → `ready_o` high in cycle N+1+`WAIT_CYCLES` (between edges N+WAIT_CYCLES and N+WAIT_CYCLES+1).
- `WAIT_CYCLES`=0 matches the previous block's read latency: data is valid the cycle after the request edge.
- Throughput:
  - `WAIT_CYCLES`=0, `mem_req_i` held high: one access per cycle; `ready_o` stays high continuously, each cycle being a separate response.
  - `WAIT_CYCLES`=W: one access per W+1 cycles, because back-to-back acceptance happens in RESP.
- Read after write to the same word with `WAIT_CYCLES`=0 (write accepted at edge N, read at edge N+1): the read returns the newly written bytes.
- `err_o` is 0 whenever `ready_o` is 0.
- Reset mid-operation: a pending write in WAIT is discarded with memory unchanged, and no `ready_o` pulse is produced.

## Test plan
- Reset then idle: assert `rst_ni`=0 mid-cycle → outputs go to 0 immediately, not at the next edge; release reset with no request → `ready_o` stays 0.
- `WAIT_CYCLES`=0 write/read: write 32'hDEAD_BEEF to 0x10 with strobes 4'hF, then read 0x10 on the next edge → `ready_o` is high for both responses, and the read returns 32'hDEAD_BEEF one cycle after its request edge.
- Byte strobes: word 0x20 holds 32'h1122_3344; write 32'hAABB_CCDD with strobes 4'b0101 → a read of 0x20 returns 32'h11BB_33DD; a write with strobes 4'b0000 leaves the word unchanged.
- `WAIT_CYCLES`=3: read request at edge N with `mem_req_i` dropped afterwards → `ready_o` is high only in cycle N+4; toggling `addr_i` during WAIT has no effect.
- Errors: read 0x0000_0002 (misaligned), and with `DEPTH_WORDS`=4096 read 0x0000_4000 → each gives `ready_o`=1, `err_o`=1, `read_data_o`=0. A write to 0x0000_4000 leaves word 0 intact.
- Reset during WAIT (`WAIT_CYCLES`=3): write 32'h5555_5555 to 0x8 (word previously 0) and assert reset one cycle after acceptance → no `ready_o` pulse; a later read of 0x8 returns 0.
